// File: rtl/i2s_mic_array_rx.sv
`default_nettype none
// ============================================================================
// Module  : i2s_mic_array_rx
// Purpose : Shared-clock I2S mic array receiver; left-slot words captured per
//           frame, presented as a parallel snapshot and as a per-channel stream.
// Rev     : 1.0
// ============================================================================
module i2s_mic_array_rx #(
    parameter int N_CH       = 3,
    parameter int MIC_BITS   = 24,
    parameter int SAMPLE_W   = 16,
    parameter int BCLK_HALF  = 16,
    parameter int SLOT_BCLKS = 32
) (
    input  logic                                       clk_in,
    input  logic                                       rst_n_in,
    input  logic                                       enable_in,
    input  logic [N_CH-1:0]                            ch_en_in,
    input  logic [N_CH-1:0]                            mic_data_in,
    output logic                                       bclk_out,
    output logic                                       lrcl_out,
    output logic [N_CH*SAMPLE_W-1:0]                   samples_out,
    output logic                                       frame_valid_out,
    output logic [SAMPLE_W-1:0]                        m_tdata,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] m_tchan,
    output logic                                       m_tvalid,
    input  logic                                       m_tready,
    output logic                                       m_tlast,
    output logic                                       overflow_out,
    input  logic                                       clear_ovf_in
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int B_W   = $clog2(2 * SLOT_BCLKS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF - 1);
    localparam logic [B_W-1:0]   B_LAST     = B_W'(2 * SLOT_BCLKS - 1);
    localparam logic [B_W-1:0]   B_SLOT     = B_W'(SLOT_BCLKS);
    localparam logic [B_W-1:0]   B_MSB      = B_W'(1);
    localparam logic [B_W-1:0]   B_LSB      = B_W'(MIC_BITS);

    logic [DIV_W-1:0]         div_q;
    logic [B_W-1:0]           b_q;
    logic [B_W-1:0]           b_d;
    logic                     bclk_q;
    logic                     lrcl_q;
    logic                     div_wrap;
    logic                     bclk_rise;
    logic                     bclk_fall;
    logic                     capture;
    logic                     latch;

    logic [N_CH-1:0]          sync1_q;
    logic [N_CH-1:0]          sync2_q;
    logic [MIC_BITS-1:0]      word_q [N_CH];
    logic [N_CH*SAMPLE_W-1:0] samples_q;
    logic                     frame_valid_q;

    logic [N_CH-1:0]          pend_q;
    logic [N_CH-1:0]          pend_d;
    logic [N_CH-1:0]          cur_oh;
    logic [N_CH-1:0]          pend_rest;
    logic [N_CH-1:0]          pend_after;
    logic [CH_W-1:0]          cur;
    logic                     xfer;
    logic                     ovf_q;
    logic                     ovf_d;

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        bclk_rise = enable_in && div_wrap && !bclk_q;
        bclk_fall = enable_in && div_wrap && bclk_q;
        b_d       = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        // b=1 carries the MSB because of the one-bit I2S delay after LRCL
        capture   = bclk_rise && (b_q >= B_MSB) && (b_q <= B_LSB);
        latch     = bclk_fall && (b_d == B_SLOT);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q  <= '0;
            b_q    <= '0;
            bclk_q <= 1'b0;
            lrcl_q <= 1'b0;
        end else if (!enable_in) begin
            div_q  <= '0;
            b_q    <= '0;
            bclk_q <= 1'b0;
            lrcl_q <= 1'b0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end
            if (bclk_fall) begin
                b_q    <= b_d;
                lrcl_q <= (b_d >= B_SLOT);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            sync1_q <= mic_data_in;
            sync2_q <= sync1_q;
            for (int k = 0; k < N_CH; k++) begin
                if (!enable_in) begin
                    word_q[k] <= '0;
                end else if (capture) begin
                    word_q[k] <= {word_q[k][MIC_BITS-2:0], sync2_q[k]};
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            samples_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= latch;
            if (latch) begin
                for (int k = 0; k < N_CH; k++) begin
                    samples_q[k*SAMPLE_W +: SAMPLE_W] <=
                        ch_en_in[k] ? word_q[k][MIC_BITS-1 -: SAMPLE_W] : '0;
                end
            end
        end
    end

    // pend_q holds one bit per beat still owed; lowest set bit is on the bus
    always_comb begin
        cur = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                cur = CH_W'(k);
            end
        end
        cur_oh     = pend_q & (~pend_q + 1'b1);
        pend_rest  = pend_q & ~cur_oh;
        xfer       = (|pend_q) && m_tready;
        pend_after = xfer ? pend_rest : pend_q;
        pend_d     = latch ? ch_en_in : pend_after;
        ovf_d      = ovf_q;
        if (clear_ovf_in) begin
            ovf_d = 1'b0;
        end
        if (latch && (|pend_after)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bclk_out        = bclk_q;
    assign lrcl_out        = lrcl_q;
    assign samples_out     = samples_q;
    assign frame_valid_out = frame_valid_q;
    assign m_tvalid        = |pend_q;
    assign m_tchan         = cur;
    assign m_tdata         = samples_q[int'(cur)*SAMPLE_W +: SAMPLE_W];
    assign m_tlast         = (|pend_q) && (pend_rest == '0);
    assign overflow_out    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_mic_array_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_mic_array_rx
// Purpose : Directed bench for i2s_mic_array_rx with an I2S microphone model.
// Rev     : 1.0
// ============================================================================
module tb_i2s_mic_array_rx;

    logic        clk_in       = 1'b0;
    logic        rst_n_in     = 1'b0;
    logic        enable_in    = 1'b0;
    logic [2:0]  ch_en_in     = 3'b000;
    logic [2:0]  mic_data_in  = 3'b000;
    logic        m_tready     = 1'b0;
    logic        clear_ovf_in = 1'b0;
    logic        bclk_out;
    logic        lrcl_out;
    logic [47:0] samples_out;
    logic        frame_valid_out;
    logic [15:0] m_tdata;
    logic [1:0]  m_tchan;
    logic        m_tvalid;
    logic        m_tlast;
    logic        overflow_out;

    i2s_mic_array_rx dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .ch_en_in        (ch_en_in),
        .mic_data_in     (mic_data_in),
        .bclk_out        (bclk_out),
        .lrcl_out        (lrcl_out),
        .samples_out     (samples_out),
        .frame_valid_out (frame_valid_out),
        .m_tdata         (m_tdata),
        .m_tchan         (m_tchan),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .overflow_out    (overflow_out),
        .clear_ovf_in    (clear_ovf_in)
    );

    always #5 clk_in = ~clk_in;

    longint cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] word [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return bclk_out;
            1:       return lrcl_out;
            default: return frame_valid_out;
        endcase
    endfunction

    // Waits (bounded) for signal w to transition to lvl, sampling on negedge clk
    task automatic wait_edge(input int w, input logic lvl, input string tag, output longint t);
        logic prev;
        bit   found;
        prev  = sig(w);
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_in);
            if (sig(w) == lvl && prev != lvl) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
            prev = sig(w);
        end
        chk(tag, found, 1);
    endtask

    task automatic chk_samples(input string tag, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
        chk({tag, "_s0"}, samples_out[15:0],  e0);
        chk({tag, "_s1"}, samples_out[31:16], e1);
        chk({tag, "_s2"}, samples_out[47:32], e2);
    endtask

    // Microphone model: drives on falling BCLK, MSB one bit after the LRCL fall
    initial begin
        int   mcnt;
        logic prev_l;
        mcnt   = 0;
        prev_l = 1'b0;
        forever begin
            @(negedge bclk_out);
            #1;
            if (!enable_in || lrcl_out || prev_l) mcnt = 0;
            else mcnt = mcnt + 1;
            prev_l = lrcl_out;
            for (int k = 0; k < 3; k++) begin
                if (lrcl_out)                      mic_data_in[k] = 1'b1;
                else if (mcnt >= 1 && mcnt <= 24)  mic_data_in[k] = word[k][24-mcnt];
                else                               mic_data_in[k] = 1'b0;
            end
        end
    end

    initial begin
        longint t0, t1, t2;
        int     nfv;
        word[0] = 24'h7FFF00;
        word[1] = 24'h800000;
        word[2] = 24'h123456;
        ch_en_in = 3'b111;
        m_tready = 1'b1;

        repeat (3) @(negedge clk_in);
        chk("rst_bclk", bclk_out, 0);
        chk("rst_lrcl", lrcl_out, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_fv", frame_valid_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_samples", samples_out, 0);

        rst_n_in  = 1'b1;
        enable_in = 1'b1;

        wait_edge(0, 1'b1, "bclk_rise_a", t0);
        wait_edge(0, 1'b1, "bclk_rise_b", t1);
        chk("bclk_period", t1 - t0, 32);

        wait_edge(1, 1'b0, "lrcl_fall", t0);
        wait_edge(0, 1'b1, "bclk_rise_1", t1);
        wait_edge(0, 1'b1, "bclk_rise_2", t2);
        chk("msb_rise_delay", t2 - t0, 48);

        wait_edge(1, 1'b1, "lrcl_rise_a", t0);
        wait_edge(1, 1'b1, "lrcl_rise_b", t1);
        chk("lrcl_period", t1 - t0, 2048);

        wait_edge(2, 1'b1, "fv_a", t0);
        chk_samples("frame", 16'h7FFF, 16'h8000, 16'h1234);
        @(negedge clk_in);
        chk("fv_width", frame_valid_out, 0);
        wait_edge(2, 1'b1, "fv_b", t1);
        chk("fv_period", t1 - t0, 2048);

        // Masked frame: channels 0 and 2 only
        ch_en_in = 3'b101;
        wait_edge(2, 1'b1, "fv_mask", t0);
        chk("mask_s1_zero", samples_out[31:16], 0);
        chk("mask_b0_valid", m_tvalid, 1);
        chk("mask_b0_chan", m_tchan, 0);
        chk("mask_b0_data", m_tdata, 16'h7FFF);
        chk("mask_b0_last", m_tlast, 0);
        @(negedge clk_in);
        chk("mask_b1_valid", m_tvalid, 1);
        chk("mask_b1_chan", m_tchan, 2);
        chk("mask_b1_data", m_tdata, 16'h1234);
        chk("mask_b1_last", m_tlast, 1);
        @(negedge clk_in);
        chk("mask_done", m_tvalid, 0);

        // Beat accepted on the very cycle of the next latch is not an overflow
        ch_en_in = 3'b001;
        m_tready = 1'b0;
        wait_edge(2, 1'b1, "fv_edge_a", t0);
        repeat (2047) @(negedge clk_in);
        m_tready = 1'b1;
        @(negedge clk_in);
        chk("edge_fv", frame_valid_out, 1);
        chk("edge_no_ovf", overflow_out, 0);
        chk("edge_new_valid", m_tvalid, 1);
        chk("edge_new_last", m_tlast, 1);
        m_tready = 1'b0;

        // Undrained beat at the next latch: overflow, restart at lowest channel
        ch_en_in = 3'b111;
        wait_edge(2, 1'b1, "fv_ovf", t0);
        chk("ovf_set", overflow_out, 1);
        chk("ovf_valid", m_tvalid, 1);
        chk("ovf_chan", m_tchan, 0);
        chk("ovf_data", m_tdata, 16'h7FFF);
        chk("ovf_last", m_tlast, 0);
        repeat (100) @(negedge clk_in);
        chk("hold_valid", m_tvalid, 1);
        chk("hold_chan", m_tchan, 0);
        chk("hold_data", m_tdata, 16'h7FFF);
        clear_ovf_in = 1'b1;
        @(negedge clk_in);
        clear_ovf_in = 1'b0;
        chk("ovf_cleared", overflow_out, 0);

        // Disable at b=10 then re-enable with new mic words
        m_tready = 1'b1;
        wait_edge(1, 1'b0, "dis_lrcl_fall", t0);
        for (int i = 0; i < 10; i++) wait_edge(0, 1'b0, "dis_bclk_fall", t1);
        wait_edge(0, 1'b1, "dis_bclk_rise", t1);
        enable_in = 1'b0;
        word[0] = 24'hA5A5FF;
        word[1] = 24'h000100;
        word[2] = 24'hFFFFFF;
        @(negedge clk_in);
        chk("dis_bclk", bclk_out, 0);
        chk("dis_lrcl", lrcl_out, 0);
        nfv = 0;
        repeat (3000) begin
            @(negedge clk_in);
            if (frame_valid_out) nfv++;
        end
        chk("dis_no_fv", nfv, 0);
        enable_in = 1'b1;
        wait_edge(2, 1'b1, "fv_reen", t0);
        chk_samples("reen", 16'hA5A5, 16'h0001, 16'hFFFF);

        // Asynchronous reset while a beat is held and overflow is set
        repeat (5) @(negedge clk_in);
        m_tready = 1'b0;
        wait_edge(2, 1'b1, "fv_r1", t0);
        wait_edge(2, 1'b1, "fv_r2", t1);
        chk("pre_rst_valid", m_tvalid, 1);
        chk("pre_rst_ovf", overflow_out, 1);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (bclk_out) break;
        end
        chk("pre_rst_bclk", bclk_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_tvalid", m_tvalid, 0);
        chk("arst_bclk", bclk_out, 0);
        chk("arst_ovf", overflow_out, 0);
        chk("arst_samples", samples_out, 0);

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
